// File: rtl/cache_arbiter_if.sv
// Whole-line request/response port shared by the I-cache, D-cache and adaptor sides
// of cache_arbiter. The master drives the request; the slave returns data and resp.
interface cache_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [LINE_W-1:0] wdata;
   logic [LINE_W-1:0] rdata;
   logic              resp;

   modport master (
      output read, write, addr, wdata,
      input  rdata, resp
   );

   modport slave (
      input  read, write, addr, wdata,
      output rdata, resp
   );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates whole-line misses/writebacks from the I-cache and D-cache onto the single
// cacheline adaptor port, one transaction at a time, returning resp only to the winner.
module cache_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int LINE_W      = 256,
   parameter bit ROUND_ROBIN = 1'b1
) (
   input logic            clk,
   input logic            rst,
   cache_arbiter_if.slave  i_bus,
   cache_arbiter_if.slave  d_bus,
   cache_arbiter_if.master m_bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      DONE   = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              last_d_q, last_d_d;   // 1: most recent grant went to the D-cache
   logic              m_read_q, m_read_d;
   logic              m_write_q, m_write_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [LINE_W-1:0] m_wdata_q, m_wdata_d;

   logic i_req;
   logic d_req;
   logic grant_d;

   assign i_req   = i_bus.read;
   assign d_req   = d_bus.read | d_bus.write;
   assign grant_d = d_req & (~i_req | ~ROUND_ROBIN | ~last_d_q);

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         last_d_q  <= 1'b0;
         m_read_q  <= 1'b0;
         m_write_q <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         last_d_q  <= last_d_d;
         m_read_q  <= m_read_d;
         m_write_q <= m_write_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
      end
   end

   // NOTE: every signal gets a hold default first, so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      last_d_d  = last_d_q;
      m_read_d  = m_read_q;
      m_write_d = m_write_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      unique case (state_q)
         IDLE: begin
            if (i_req | d_req) begin
               last_d_d = grant_d;
               if (grant_d) begin
                  state_d   = BUSY_D;
                  m_addr_d  = d_bus.addr;
                  m_write_d = d_bus.write;
                  m_read_d  = ~d_bus.write;   // a simultaneous read is dropped in favour of the writeback
                  if (d_bus.write) m_wdata_d = d_bus.wdata;
               end else begin
                  state_d   = BUSY_I;
                  m_addr_d  = i_bus.addr;
                  m_read_d  = 1'b1;
                  m_write_d = 1'b0;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            if (m_bus.resp) begin
               state_d   = DONE;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      i_bus.resp = 1'b0;
      d_bus.resp = 1'b0;
      if (!rst && m_bus.resp) begin
         i_bus.resp = (state_q == BUSY_I);
         d_bus.resp = (state_q == BUSY_D);
      end
   end

   assign i_bus.rdata = m_bus.rdata;
   assign d_bus.rdata = m_bus.rdata;
   assign m_bus.read  = m_read_q;
   assign m_bus.write = m_write_q;
   assign m_bus.addr  = m_addr_q;
   assign m_bus.wdata = m_wdata_q;

endmodule
